vec_mul_tile_sequencer: RTL and testbench

//  Parametrised control engine for the vector-multiply datapath: Unified Buffer -> weight FIFO -> vec_mul -> result SRAM.

---
 rtl/vec_mul_tile_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_vec_mul_tile_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_mul_tile_sequencer.sv
// Job sequencer for the vector-multiply datapath: weight FIFO pop, PE reload, UB streaming, result writes.
// Optional performance counters (perf_cycles, perf_stall) are built when VEC_MUL_PERF_CNT_EN is defined.
module vec_mul_tile_sequencer #(
  parameter int ADDRESSSIZE = 10,
  parameter int VEC_CNT_BW  = 8,
  parameter int TILE_CNT_BW = 4,
  parameter int PIPE_LAT    = 2
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic                   abort,
  input  logic [ADDRESSSIZE-1:0] cfg_ub_base,
  input  logic [ADDRESSSIZE-1:0] cfg_res_base,
  input  logic [VEC_CNT_BW-1:0]  cfg_num_vecs,
  input  logic [TILE_CNT_BW-1:0] cfg_num_tiles,
  input  logic                   fifo_empty,
  output logic                   fifo_read_enable,
  output logic                   weight_reload,
  output logic [ADDRESSSIZE-1:0] ub_addr,
  output logic                   ub_addr_valid,
  output logic                   result_we,
  output logic [ADDRESSSIZE-1:0] result_addr,
  output logic                   busy,
  output logic                   done
`ifdef VEC_MUL_PERF_CNT_EN
  ,
  output logic [31:0]            perf_cycles,
  output logic [31:0]            perf_stall
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WLOAD  = 3'd1,
    S_RELOAD = 3'd2,
    S_STREAM = 3'd3,
    S_DRAIN  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDRESSSIZE-1:0] ub_base_q, ub_base_d;
  logic [ADDRESSSIZE-1:0] ub_addr_q, ub_addr_d;
  logic [ADDRESSSIZE-1:0] result_addr_q, result_addr_d;
  logic [VEC_CNT_BW-1:0]  num_vecs_q, num_vecs_d;
  logic [VEC_CNT_BW-1:0]  vec_cnt_q, vec_cnt_d;
  logic [TILE_CNT_BW-1:0] num_tiles_q, num_tiles_d;
  logic [TILE_CNT_BW-1:0] tile_idx_q, tile_idx_d;
  logic [PIPE_LAT-1:0]    dl_q, dl_d;
  logic [PIPE_LAT:0]      dl_shift;
  logic                   weight_reload_q, weight_reload_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   start_ok;
  logic                   pop;
`ifdef VEC_MUL_PERF_CNT_EN
  logic [31:0]            perf_cycles_q, perf_cycles_d;
  logic [31:0]            perf_stall_q, perf_stall_d;
`endif

  // Next-state, next-output and counter update logic
  always_comb begin
    dl_shift        = {dl_q, valid_q};
    start_ok        = (state_q == S_IDLE) && start && !abort;
    // The pop follows the FIFO flag in the same cycle so a tile is never requested from an empty FIFO.
    pop             = (state_q == S_WLOAD) && !fifo_empty && !abort;
    state_d         = state_q;
    ub_base_d       = ub_base_q;
    ub_addr_d       = ub_addr_q;
    result_addr_d   = result_addr_q + ADDRESSSIZE'(dl_q[PIPE_LAT-1]);
    num_vecs_d      = num_vecs_q;
    vec_cnt_d       = vec_cnt_q;
    num_tiles_d     = num_tiles_q;
    tile_idx_d      = tile_idx_q;
    dl_d            = dl_shift[PIPE_LAT-1:0];
    weight_reload_d = 1'b0;
    valid_d         = 1'b0;
    done_d          = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
      dl_d    = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_ok) begin
            ub_base_d     = cfg_ub_base;
            ub_addr_d     = cfg_ub_base;
            result_addr_d = cfg_res_base;
            num_vecs_d    = cfg_num_vecs;
            num_tiles_d   = (cfg_num_tiles == '0) ? TILE_CNT_BW'(1) : cfg_num_tiles;
            tile_idx_d    = '0;
            vec_cnt_d     = '0;
            if (cfg_num_vecs == '0) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = S_WLOAD;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_WLOAD: begin
          if (!fifo_empty) begin
            state_d         = S_RELOAD;
            weight_reload_d = 1'b1;
            ub_addr_d       = ub_base_q;
          end else begin
            state_d = S_WLOAD;
          end
        end
        S_RELOAD: begin
          state_d   = S_STREAM;
          valid_d   = 1'b1;
          vec_cnt_d = '0;
        end
        S_STREAM: begin
          if (vec_cnt_q == num_vecs_q - VEC_CNT_BW'(1)) begin
            state_d = S_DRAIN;
          end else begin
            valid_d   = 1'b1;
            vec_cnt_d = vec_cnt_q + VEC_CNT_BW'(1);
            ub_addr_d = ub_addr_q + ADDRESSSIZE'(1);
          end
        end
        S_DRAIN: begin
          if (dl_q == '0) begin
            if (tile_idx_q == num_tiles_q - TILE_CNT_BW'(1)) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              state_d    = S_WLOAD;
              tile_idx_d = tile_idx_q + TILE_CNT_BW'(1);
            end
          end else begin
            state_d = S_DRAIN;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
    busy_d = (state_d != S_IDLE);
`ifdef VEC_MUL_PERF_CNT_EN
    if (start_ok) begin
      perf_cycles_d = '0;
      perf_stall_d  = '0;
    end else begin
      perf_cycles_d = (busy_q && (perf_cycles_q != '1)) ? perf_cycles_q + 32'd1 : perf_cycles_q;
      perf_stall_d  = ((state_q == S_WLOAD) && fifo_empty && (perf_stall_q != '1)) ?
                      perf_stall_q + 32'd1 : perf_stall_q;
    end
`endif
  end

  // State, counters, delay line and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q         <= S_IDLE;
      ub_base_q       <= '0;
      ub_addr_q       <= '0;
      result_addr_q   <= '0;
      num_vecs_q      <= '0;
      vec_cnt_q       <= '0;
      num_tiles_q     <= '0;
      tile_idx_q      <= '0;
      dl_q            <= '0;
      weight_reload_q <= 1'b0;
      valid_q         <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
`ifdef VEC_MUL_PERF_CNT_EN
      perf_cycles_q   <= '0;
      perf_stall_q    <= '0;
`endif
    end else begin
      state_q         <= state_d;
      ub_base_q       <= ub_base_d;
      ub_addr_q       <= ub_addr_d;
      result_addr_q   <= result_addr_d;
      num_vecs_q      <= num_vecs_d;
      vec_cnt_q       <= vec_cnt_d;
      num_tiles_q     <= num_tiles_d;
      tile_idx_q      <= tile_idx_d;
      dl_q            <= dl_d;
      weight_reload_q <= weight_reload_d;
      valid_q         <= valid_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
`ifdef VEC_MUL_PERF_CNT_EN
      perf_cycles_q   <= perf_cycles_d;
      perf_stall_q    <= perf_stall_d;
`endif
    end
  end

  assign fifo_read_enable = pop;
  assign weight_reload    = weight_reload_q;
  assign ub_addr          = ub_addr_q;
  assign ub_addr_valid    = valid_q;
  assign result_we        = dl_q[PIPE_LAT-1];
  assign result_addr      = result_addr_q;
  assign busy             = busy_q;
  assign done             = done_q;
`ifdef VEC_MUL_PERF_CNT_EN
  assign perf_cycles      = perf_cycles_q;
  assign perf_stall       = perf_stall_q;
`endif

endmodule

// File: tb/tb_vec_mul_tile_sequencer.sv
// Self-checking bench for vec_mul_tile_sequencer: randomized jobs against a cycle-timeline reference model.
module tb_vec_mul_tile_sequencer;
  localparam int AW    = 10;
  localparam int VB    = 8;
  localparam int TB    = 4;
  localparam int PL    = 2;
  localparam int MAXC  = 600;
  localparam int AMASK = (1 << AW) - 1;

  logic          clk, rstn, start, abort, fifo_empty;
  logic [AW-1:0] cfg_ub_base, cfg_res_base;
  logic [VB-1:0] cfg_num_vecs;
  logic [TB-1:0] cfg_num_tiles;
  logic          fifo_read_enable, weight_reload, ub_addr_valid, result_we, busy, done;
  logic [AW-1:0] ub_addr, result_addr;
`ifdef VEC_MUL_PERF_CNT_EN
  logic [31:0]   perf_cycles, perf_stall;
`endif

  int n_tests, n_fail;
  int emp[MAXC];
  int e_pop[MAXC], e_rel[MAXC], e_val[MAXC], e_we[MAXC], e_busy[MAXC], e_done[MAXC], e_stl[MAXC];
  int e_ub[MAXC], e_ra[MAXC];
  int e_last, e_end, m_pc, m_ps;
  int obs_done_cyc, obs_dones, obs_pops, obs_writes, obs_last_ra;

  vec_mul_tile_sequencer #(.ADDRESSSIZE(AW), .VEC_CNT_BW(VB), .TILE_CNT_BW(TB), .PIPE_LAT(PL)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .cfg_ub_base(cfg_ub_base), .cfg_res_base(cfg_res_base),
    .cfg_num_vecs(cfg_num_vecs), .cfg_num_tiles(cfg_num_tiles),
    .fifo_empty(fifo_empty), .fifo_read_enable(fifo_read_enable), .weight_reload(weight_reload),
    .ub_addr(ub_addr), .ub_addr_valid(ub_addr_valid), .result_we(result_we),
    .result_addr(result_addr), .busy(busy), .done(done)
`ifdef VEC_MUL_PERF_CNT_EN
    , .perf_cycles(perf_cycles), .perf_stall(perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Timeline model: cycle 0 is the start cycle; each tile is wait/pop, reload, stream, drain.
  task automatic build_model(input int v, input int t, input int ub, input int rb, input int ab);
    int c, tt, ra;
    for (int i = 0; i < MAXC; i++) begin
      e_pop[i] = 0; e_rel[i] = 0; e_val[i] = 0; e_we[i] = 0;
      e_busy[i] = 0; e_done[i] = 0; e_stl[i] = 0; e_ub[i] = 0; e_ra[i] = 0;
    end
    tt = (t == 0) ? 1 : t;
    ra = rb;
    if (v == 0) begin
      e_busy[1] = 1; e_done[1] = 1; e_last = 1;
    end else begin
      c = 1;
      for (int k = 0; k < tt; k++) begin
        while (emp[c] != 0 && c < MAXC - 100) begin
          e_busy[c] = 1; e_stl[c] = 1; c++;
        end
        e_pop[c] = 1; e_busy[c] = 1; e_rel[c+1] = 1; e_busy[c+1] = 1;
        c = c + 2;
        for (int i = 0; i < v; i++) begin
          e_val[c+i] = 1; e_ub[c+i] = (ub + i) & AMASK;
          e_we[c+i+PL] = 1; e_ra[c+i+PL] = ra;
          ra = (ra + 1) & AMASK;
        end
        for (int i = c; i <= c + v + PL; i++) e_busy[i] = 1;
        c = c + v + PL + 1;
      end
      e_busy[c] = 1; e_done[c] = 1; e_last = c;
    end
    e_end = e_last;
    if (ab >= 0) begin
      if (ab > e_end) e_end = ab;
      e_pop[ab] = 0;
      for (int i = ab + 1; i < MAXC; i++) begin
        e_pop[i] = 0; e_rel[i] = 0; e_val[i] = 0; e_we[i] = 0;
        e_busy[i] = 0; e_done[i] = 0; e_stl[i] = 0;
      end
    end
    if (ab != 0) begin
      m_pc = 0; m_ps = 0;
      for (int i = 0; i < MAXC; i++) begin
        m_pc += e_busy[i]; m_ps += e_stl[i];
      end
    end
  endtask

  task automatic run_job(input string name, input int v, input int t, input int ub, input int rb, input int ab);
    logic [5:0] exp_s, got_s;
    build_model(v, t, ub, rb, ab);
    obs_done_cyc = -1; obs_dones = 0; obs_pops = 0; obs_writes = 0; obs_last_ra = -1;
    for (int c = 0; c <= e_end + 2; c++) begin
      @(posedge clk);
      #1;
      start      = (c == 0) || ((ab < 0 || c < ab) && e_busy[c] != 0 && $urandom_range(0, 3) == 0);
      abort      = (c == ab);
      fifo_empty = (emp[c] != 0);
      if (c == 0) begin
        cfg_ub_base = AW'(ub); cfg_res_base = AW'(rb); cfg_num_vecs = VB'(v); cfg_num_tiles = TB'(t);
      end else begin
        cfg_ub_base = AW'($urandom); cfg_res_base = AW'($urandom);
        cfg_num_vecs = VB'($urandom); cfg_num_tiles = TB'($urandom);
      end
      @(negedge clk);
      got_s = {fifo_read_enable, weight_reload, ub_addr_valid, result_we, busy, done};
      exp_s = {e_pop[c] != 0, e_rel[c] != 0, e_val[c] != 0, e_we[c] != 0, e_busy[c] != 0, e_done[c] != 0};
      n_tests++;
      if (got_s !== exp_s) begin
        n_fail++;
        $display("FAIL %s strobes cyc %0d: got %b expected %b (pop,reload,valid,we,busy,done)", name, c, got_s, exp_s);
      end
      if (e_val[c] != 0) begin
        n_tests++;
        if (ub_addr !== AW'(e_ub[c])) begin
          n_fail++;
          $display("FAIL %s ub_addr cyc %0d: got %h expected %h", name, c, ub_addr, e_ub[c]);
        end
      end
      if (e_we[c] != 0) begin
        n_tests++;
        if (result_addr !== AW'(e_ra[c])) begin
          n_fail++;
          $display("FAIL %s result_addr cyc %0d: got %h expected %h", name, c, result_addr, e_ra[c]);
        end
      end
      if (done === 1'b1) begin
        obs_dones++;
        if (obs_done_cyc < 0) obs_done_cyc = c;
      end
      if (fifo_read_enable === 1'b1) obs_pops++;
      if (result_we === 1'b1) begin
        obs_writes++; obs_last_ra = int'(result_addr);
      end
    end
`ifdef VEC_MUL_PERF_CNT_EN
    n_tests++;
    if (perf_cycles !== 32'(m_pc) || perf_stall !== 32'(m_ps)) begin
      n_fail++;
      $display("FAIL %s perf: got cycles %0d stall %0d expected %0d %0d", name, perf_cycles, perf_stall, m_pc, m_ps);
    end
`endif
    for (int i = 0; i < MAXC; i++) emp[i] = 0;
    start = 1'b0; abort = 1'b0; fifo_empty = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; start = 1'b0; abort = 1'b0; fifo_empty = 1'b0;
    cfg_ub_base = '0; cfg_res_base = '0; cfg_num_vecs = '0; cfg_num_tiles = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({fifo_read_enable, weight_reload, ub_addr_valid, result_we, busy, done, ub_addr, result_addr} !== 26'd0) begin
      n_fail++;
      $display("FAIL reset outputs: got %b%b%b%b%b%b %h %h expected all zero", fifo_read_enable, weight_reload,
               ub_addr_valid, result_we, busy, done, ub_addr, result_addr);
    end
`ifdef VEC_MUL_PERF_CNT_EN
    n_tests++;
    if (perf_cycles !== 32'd0 || perf_stall !== 32'd0) begin
      n_fail++;
      $display("FAIL reset perf: got %0d %0d expected 0 0", perf_cycles, perf_stall);
    end
`endif
    @(posedge clk);
    #1 rstn = 1'b1;
    m_pc = 0; m_ps = 0;
  endtask

  task automatic test_basic_job();
    run_job("basic", 4, 1, 'h10, 'h20, -1);
    n_tests++;
    if (obs_done_cyc !== 10 || obs_pops !== 1 || obs_writes !== 4 || obs_last_ra !== 'h23) begin
      n_fail++;
      $display("FAIL basic summary: got done@%0d pops %0d writes %0d last %h expected 10 1 4 23",
               obs_done_cyc, obs_pops, obs_writes, obs_last_ra);
    end
  endtask

  task automatic test_multi_tile();
    run_job("multi_tile", 3, 3, 0, 0, -1);
    n_tests++;
    if (obs_pops !== 3 || obs_dones !== 1 || obs_writes !== 9 || obs_last_ra !== 8) begin
      n_fail++;
      $display("FAIL multi_tile summary: got pops %0d dones %0d writes %0d last %0d expected 3 1 9 8",
               obs_pops, obs_dones, obs_writes, obs_last_ra);
    end
  endtask

  task automatic test_fifo_stall();
    for (int i = 1; i <= 5; i++) emp[i] = 1;
    run_job("fifo_stall", 4, 1, 'h10, 'h20, -1);
    n_tests++;
    if (obs_done_cyc !== 15 || obs_pops !== 1) begin
      n_fail++;
      $display("FAIL fifo_stall summary: got done@%0d pops %0d expected 15 1", obs_done_cyc, obs_pops);
    end
`ifdef VEC_MUL_PERF_CNT_EN
    n_tests++;
    if (perf_stall !== 32'd5) begin
      n_fail++;
      $display("FAIL fifo_stall perf_stall: got %0d expected 5", perf_stall);
    end
`endif
  endtask

  task automatic test_degenerate();
    run_job("vecs0", 0, 2, 'h33, 'h44, -1);
    n_tests++;
    if (obs_done_cyc !== 1 || obs_pops !== 0 || obs_writes !== 0) begin
      n_fail++;
      $display("FAIL vecs0 summary: got done@%0d pops %0d writes %0d expected 1 0 0", obs_done_cyc, obs_pops, obs_writes);
    end
    run_job("tiles0", 4, 0, 'h10, 'h20, -1);
    n_tests++;
    if (obs_done_cyc !== 10 || obs_pops !== 1) begin
      n_fail++;
      $display("FAIL tiles0 summary: got done@%0d pops %0d expected 10 1", obs_done_cyc, obs_pops);
    end
  endtask

  task automatic test_wrap();
    run_job("wrap", 4, 1, 'h3FF, 'h3FE, -1);
    n_tests++;
    if (obs_writes !== 4 || obs_last_ra !== 1) begin
      n_fail++;
      $display("FAIL wrap summary: got writes %0d last %h expected 4 001", obs_writes, obs_last_ra);
    end
  endtask

  task automatic test_abort();
    run_job("abort_stream", 6, 2, 'h40, 'h80, 5);
    n_tests++;
    if (obs_dones !== 0 || obs_writes !== 1) begin
      n_fail++;
      $display("FAIL abort summary: got dones %0d writes %0d expected 0 1", obs_dones, obs_writes);
    end
    run_job("after_abort", 2, 2, 'h100, 'h200, -1);
    n_tests++;
    if (obs_dones !== 1 || obs_writes !== 4 || obs_last_ra !== 'h203) begin
      n_fail++;
      $display("FAIL after_abort summary: got dones %0d writes %0d last %h expected 1 4 203",
               obs_dones, obs_writes, obs_last_ra);
    end
    run_job("abort_with_start", 3, 1, 'h10, 'h20, 0);
    n_tests++;
    if (obs_dones !== 0 || obs_pops !== 0) begin
      n_fail++;
      $display("FAIL abort_with_start summary: got dones %0d pops %0d expected 0 0", obs_dones, obs_pops);
    end
  endtask

  task automatic test_back_to_back();
    int v, t, ab;
    for (int j = 0; j < 25; j++) begin
      v  = $urandom_range(0, 12);
      t  = $urandom_range(0, 4);
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : -1;
      for (int i = 1; i < MAXC; i++) emp[i] = ($urandom_range(0, 3) == 0) ? 1 : 0;
      run_job("random", v, t, int'($urandom_range(0, AMASK)), int'($urandom_range(0, AMASK)), ab);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < MAXC; i++) emp[i] = 0;
    test_reset();
    test_basic_job();
    test_multi_tile();
    test_fifo_stall();
    test_degenerate();
    test_wrap();
    test_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
